// File: rtl/fix_muldiv_seq.sv
// fix_muldiv_seq: signed Q(WS-DP).DP multiply/divide unit behind valid/ready handshakes.
// Multiply is a single cycle with round-half-up and saturation. Divide is a
// bit-serial restoring divider on the operand magnitudes, WS+DP cycles per result.
module fix_muldiv_seq #(
  parameter int unsigned WS = 16,
  parameter int unsigned DP = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          op,
  input  logic [WS-1:0] a,
  input  logic [WS-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WS-1:0] c,
  output logic          ovf,
  output logic          dz
);

  localparam int unsigned NW = WS + DP;           // divider dividend / quotient width
  localparam int unsigned PW = 2 * WS;            // full product width
  localparam int unsigned CW = $clog2(NW + 1);    // iteration counter width

  localparam logic [WS-1:0]        MAX_V = {1'b0, {(WS-1){1'b1}}};
  localparam logic [WS-1:0]        MIN_V = {1'b1, {(WS-1){1'b0}}};
  localparam logic signed [PW-1:0] MAX_P = {{(WS+1){1'b0}}, {(WS-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_P = {{(WS+1){1'b1}}, {(WS-1){1'b0}}};
  localparam logic [PW-1:0]        RND   = PW'(1) << (DP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [WS-1:0] a_q, a_d;
  logic [WS-1:0] b_q, b_d;
  logic [NW-1:0] dvd_q, dvd_d;      // dividend shifts out MSB-first, quotient shifts in
  logic [WS-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic [WS-1:0] rem_q, rem_d;      // partial remainder, always below the divisor
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WS-1:0] c_q, c_d;
  logic          ovf_q, ovf_d;
  logic          dz_q, dz_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;

  // Operand magnitudes; the most negative value maps to 2^(WS-1) as unsigned
  logic [WS-1:0] a_mag, b_mag;

  always_comb begin
    a_mag = a[WS-1] ? (~a + WS'(1)) : a;
    b_mag = b[WS-1] ? (~b + WS'(1)) : b;
  end

  // Multiply: full signed product, round half toward +inf, saturate to WS bits
  logic signed [PW-1:0] a_ext, b_ext, prod, prod_rnd, mul_r;
  logic [WS-1:0]        mul_c;
  logic                 mul_ovf;

  always_comb begin
    a_ext    = {{WS{a_q[WS-1]}}, a_q};
    b_ext    = {{WS{b_q[WS-1]}}, b_q};
    prod     = a_ext * b_ext;
    prod_rnd = prod + RND;
    mul_r    = prod_rnd >>> DP;
    mul_c    = mul_r[WS-1:0];
    mul_ovf  = 1'b0;
    if (mul_r > MAX_P) begin
      mul_c   = MAX_V;
      mul_ovf = 1'b1;
    end else if (mul_r < MIN_P) begin
      mul_c   = MIN_V;
      mul_ovf = 1'b1;
    end
  end

  // One restoring-division step: shift in next dividend bit, subtract if it fits
  logic [WS:0]   rem_sh;
  logic [WS-1:0] rem_sub, rem_nx;
  logic          q_bit;
  logic [NW-1:0] quo_nx;

  always_comb begin
    rem_sh  = {rem_q, dvd_q[NW-1]};
    q_bit   = (rem_sh >= {1'b0, dvs_q});
    rem_sub = rem_sh[WS-1:0] - dvs_q;
    rem_nx  = q_bit ? rem_sub : rem_sh[WS-1:0];
    quo_nx  = {dvd_q[NW-2:0], q_bit};
  end

  // Divide result from the final quotient: sign fix-up, saturation, divide-by-zero
  logic          div_sign;
  logic [WS-1:0] div_q_lo, div_c;
  logic          div_ovf, div_dz;

  always_comb begin
    div_sign = a_q[WS-1] ^ b_q[WS-1];
    div_q_lo = quo_nx[WS-1:0];
    div_c    = div_sign ? (~div_q_lo + WS'(1)) : div_q_lo;
    div_ovf  = 1'b0;
    div_dz   = 1'b0;
    if (b_q == '0) begin
      div_c  = a_q[WS-1] ? MIN_V : MAX_V;
      div_dz = 1'b1;
    end else if (!div_sign && (quo_nx > NW'(MAX_V))) begin
      div_c   = MAX_V;
      div_ovf = 1'b1;
    end else if (div_sign && (quo_nx > NW'(MIN_V))) begin
      div_c   = MIN_V;
      div_ovf = 1'b1;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b;
          dvd_d      = {a_mag, {DP{1'b0}}};
          dvs_d      = b_mag;
          rem_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = op ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        c_d         = mul_c;
        ovf_d       = mul_ovf;
        dz_d        = 1'b0;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DIV: begin
        dvd_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NW - 1)) begin
          c_d         = div_c;
          ovf_d       = div_ovf;
          dz_d        = div_dz;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      c_q         <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_fix_muldiv_seq.sv
// Testbench for fix_muldiv_seq: directed and random operands against an integer reference model.
module tb_fix_muldiv_seq;

  localparam int WS = 16;
  localparam int DP = 8;
  localparam logic [WS-1:0] MAXV = 16'h7FFF;
  localparam logic [WS-1:0] MINV = 16'h8000;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          op;
  logic [WS-1:0] a;
  logic [WS-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [WS-1:0] c;
  logic          ovf;
  logic          dz;

  int vectors     = 0;
  int miscompares = 0;

  fix_muldiv_seq #(.WS(WS), .DP(DP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .ovf       (ovf),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic longint sx(input logic [WS-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic void mul_ref(input logic [WS-1:0] av, input logic [WS-1:0] bv,
                                  output logic [WS-1:0] rc, output logic rovf);
    longint p, r, mx, mn;
    mx   = (longint'(1) <<< (WS - 1)) - 1;
    mn   = -(longint'(1) <<< (WS - 1));
    p    = sx(av) * sx(bv);
    r    = (p + (longint'(1) <<< (DP - 1))) >>> DP;
    rovf = 1'b0;
    if (r > mx) begin
      r = mx; rovf = 1'b1;
    end else if (r < mn) begin
      r = mn; rovf = 1'b1;
    end
    rc = r[WS-1:0];
  endfunction

  function automatic void div_ref(input logic [WS-1:0] av, input logic [WS-1:0] bv,
                                  output logic [WS-1:0] rc, output logic rovf, output logic rdz);
    longint sa, sb, ma, mb, q, r, lim;
    bit s;
    sa   = sx(av);
    sb   = sx(bv);
    lim  = longint'(1) <<< (WS - 1);
    rovf = 1'b0;
    rdz  = 1'b0;
    if (sb == 0) begin
      rc  = (sa < 0) ? MINV : MAXV;
      rdz = 1'b1;
      return;
    end
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    q  = (ma <<< DP) / mb;
    s  = (sa < 0) != (sb < 0);
    if (!s && q > lim - 1) begin
      r = lim - 1; rovf = 1'b1;
    end else if (s && q > lim) begin
      r = -lim; rovf = 1'b1;
    end else begin
      r = s ? -q : q;
    end
    rc = r[WS-1:0];
  endfunction

  function automatic logic [WS-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return MINV;
      2: return MAXV;
      3: return '1;
      4: return WS'($urandom_range(0, 1023));
      default: return WS'($urandom);
    endcase
  endfunction

  // ---------------- drivers ----------------
  // Present one operation, wait for its result; lat is cycles from accept edge, -1 on timeout.
  task automatic run_op(input logic o, input logic [WS-1:0] av, input logic [WS-1:0] bv,
                        output logic [WS-1:0] rc, output logic rovf, output logic rdz,
                        output int lat);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 1'($urandom); a = WS'($urandom); b = WS'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
    rc = c; rovf = ovf; rdz = dz;
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    vectors++; if (c !== '0) begin miscompares++; $display("FAIL reset c: got %h expected 0000", c); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset ovf: got %b expected 0", ovf); end
    vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL reset dz: got %b expected 0", dz); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL post-reset idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  typedef struct {
    logic          o;
    logic [WS-1:0] a;
    logic [WS-1:0] b;
    logic [WS-1:0] c;
    logic          ovf;
    logic          dz;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[15];
    logic [WS-1:0] rc;
    logic rovf, rdz;
    int lat, elat;
    tbl[0]  = '{1'b0, 16'h0180, 16'h0200, 16'h0300, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 16'hFE80, 16'h0200, 16'hFD00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 16'h0001, 16'h0080, 16'h0001, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 16'hFFFF, 16'h0080, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 16'h7F00, 16'h0200, 16'h7FFF, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 16'h8000, 16'h0200, 16'h8000, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 16'h7F00, 16'h0001, 16'h7FFF, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0};
    for (int i = 0; i < 15; i++) begin
      elat = tbl[i].o ? (WS + DP) : 1;
      run_op(tbl[i].o, tbl[i].a, tbl[i].b, rc, rovf, rdz, lat);
      vectors++; if (lat !== elat) begin miscompares++; $display("FAIL directed[%0d] latency: got %0d expected %0d", i, lat, elat); end
      vectors++; if (rc !== tbl[i].c) begin miscompares++; $display("FAIL directed[%0d] c: got %h expected %h", i, rc, tbl[i].c); end
      vectors++; if (rovf !== tbl[i].ovf) begin miscompares++; $display("FAIL directed[%0d] ovf: got %b expected %b", i, rovf, tbl[i].ovf); end
      vectors++; if (rdz !== tbl[i].dz) begin miscompares++; $display("FAIL directed[%0d] dz: got %b expected %b", i, rdz, tbl[i].dz); end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [WS-1:0] av, bv, rc, ec;
    logic o, rovf, rdz, eovf, edz;
    int lat, elat;
    for (int i = 0; i < 40; i++) begin
      o  = 1'($urandom);
      av = pick();
      bv = pick();
      if (o) div_ref(av, bv, ec, eovf, edz);
      else begin mul_ref(av, bv, ec, eovf); edz = 1'b0; end
      elat = o ? (WS + DP) : 1;
      run_op(o, av, bv, rc, rovf, rdz, lat);
      vectors++; if (lat !== elat || rc !== ec || rovf !== eovf || rdz !== edz) begin
        miscompares++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: got c=%h ovf=%b dz=%b lat=%0d expected c=%h ovf=%b dz=%b lat=%0d",
                 i, o, av, bv, rc, rovf, rdz, lat, ec, eovf, edz, elat);
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      release_out();
    end
  endtask

  task automatic test_stall();
    logic [WS-1:0] rc;
    logic rovf, rdz;
    int lat;
    run_op(1'b1, 16'h0300, 16'h0200, rc, rovf, rdz, lat);
    vectors++; if (rc !== 16'h0180 || lat !== WS + DP) begin
      miscompares++; $display("FAIL stall setup: got c=%h lat=%0d expected c=0180 lat=%0d", rc, lat, WS + DP);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0); op = 1'($urandom); a = WS'($urandom); b = WS'($urandom);
      @(posedge clk);
      #1;
      vectors++; if (out_valid !== 1'b1 || c !== 16'h0180 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall cycle %0d: got out_valid=%b c=%h in_ready=%b expected 1/0180/0", i, out_valid, c, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 16'h0180) begin
      miscompares++;
      $display("FAIL stall release: got in_ready=%b out_valid=%b c=%h expected 1/0/0180", in_ready, out_valid, c);
    end
    @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL stall idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_div();
    logic [WS-1:0] rc;
    logic rovf, rdz;
    int lat;
    @(negedge clk);
    in_valid = 1'b1; op = 1'b1; a = 16'h7F00; b = 16'h0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== '0 || ovf !== 1'b0 || dz !== 1'b0) begin
      miscompares++;
      $display("FAIL mid-div reset: got in_ready=%b out_valid=%b c=%h ovf=%b dz=%b expected 1/0/0000/0/0",
               in_ready, out_valid, c, ovf, dz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b1, 16'h0300, 16'h0200, rc, rovf, rdz, lat);
    vectors++; if (rc !== 16'h0180 || rovf !== 1'b0 || rdz !== 1'b0 || lat !== WS + DP) begin
      miscompares++;
      $display("FAIL after reset divide: got c=%h ovf=%b dz=%b lat=%0d expected 0180/0/0/%0d", rc, rovf, rdz, lat, WS + DP);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [WS-1:0] va[5], vb[5];
    logic [WS-1:0] ec;
    logic eo;
    int acc, del, last;
    acc = 0; del = 0; last = -100;
    for (int i = 0; i < 5; i++) begin va[i] = pick(); vb[i] = pick(); end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = 1'b0; a = va[0]; b = vb[0];
    for (int cyc = 0; cyc < 40 && del < 5; cyc++) begin
      logic wa, wd;
      wa = in_valid && in_ready;
      wd = out_valid && out_ready;
      if (wd) begin
        mul_ref(va[del], vb[del], ec, eo);
        vectors++; if (c !== ec || ovf !== eo) begin
          miscompares++; $display("FAIL b2b[%0d] a=%h b=%h: got c=%h ovf=%b expected c=%h ovf=%b", del, va[del], vb[del], c, ovf, ec, eo);
        end
        if (del > 0) begin
          vectors++; if (cyc - last !== 3) begin
            miscompares++; $display("FAIL b2b[%0d] interval: got %0d expected 3", del, cyc - last);
          end
        end
        last = cyc;
        del++;
      end
      @(posedge clk);
      @(negedge clk);
      if (wa) begin
        acc++;
        if (acc < 5) begin a = va[acc]; b = vb[acc]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++; if (del !== 5) begin miscompares++; $display("FAIL b2b count: got %0d expected 5", del); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_reset_mid_div();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
